// File: rtl/mem_bank_arbiter_pkg.sv
// Shared sizes, address-field helpers and the read-tag record for the
// banked-memory arbiter.
package mem_pkg;

  localparam int AW       = 10;
  localparam int DW       = 8;
  localparam int BANK_W   = 2;
  localparam int ROW_W    = 8;
  localparam int NREQ_MAX = 4;
  localparam int IDX_W    = 2;

  function automatic logic [BANK_W-1:0] bank_of(input logic [AW-1:0] addr);
    return addr[AW-1 -: BANK_W];
  endfunction

  function automatic logic [ROW_W-1:0] row_of(input logic [AW-1:0] addr);
    return addr[ROW_W-1:0];
  endfunction

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] id;
  } rd_tag_t;

endpackage

// File: rtl/mem_bank_arbiter_rr_pick.sv
// Combinational round-robin picker: the first requester at or after ptr
// (wrapping) wins.
module rr_pick
  import mem_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  int cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = 0;
    for (int k = 0; k < NREQ; k++) begin
      cand = int'(ptr) + k;
      if (cand >= NREQ) cand = cand - NREQ;
      if (!any && req[cand[IDX_W-1:0]]) begin
        any                     = 1'b1;
        grant[cand[IDX_W-1:0]]  = 1'b1;
        idx                     = cand[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/mem_bank_arbiter.sv
// Round-robin arbiter sharing the single port of the banked memory; read
// data is steered back to the requester that issued the read.
module mem_bank_arbiter #(
  parameter int NREQ = 4,
  parameter int AW   = mem_pkg::AW,
  parameter int DW   = mem_pkg::DW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ-1:0]    req_wen,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]    req_ready,
  output logic [NREQ-1:0]    rsp_valid,
  output logic [DW-1:0]      rsp_rdata,
  output logic             mem_wen,
  output logic [AW-1:0]    mem_addr,
  output logic [DW-1:0]    mem_wdata,
  input  logic [DW-1:0]    mem_rdata
);
  import mem_pkg::*;

  logic [IDX_W-1:0] rr_ptr;
  logic [NREQ-1:0]  grant;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;
  logic             accept;
  rd_tag_t          tag_issue;
  rd_tag_t          tag_data;
  logic [DW-1:0]    rdata_hold;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // Grant is suppressed during reset so nothing is accepted while flops are held.
  assign req_ready = rst ? '0 : grant;
  assign accept    = pick_any && !rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (accept) begin
      if (pick_idx == IDX_W'(NREQ - 1)) rr_ptr <= '0;
      else                              rr_ptr <= pick_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_wen   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_wen <= accept && req_wen[pick_idx];
      if (accept) begin
        mem_addr  <= req_addr[pick_idx*AW +: AW];
        mem_wdata <= req_wdata[pick_idx*DW +: DW];
      end
    end
  end

  // The tag rides with the issue stage, then one more stage to line up
  // with the memory's synchronous read data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_issue <= '0;
      tag_data  <= '0;
    end else begin
      tag_issue.valid <= accept && !req_wen[pick_idx];
      tag_issue.id    <= pick_idx;
      tag_data        <= tag_issue;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 rdata_hold <= '0;
    else if (tag_data.valid) rdata_hold <= mem_rdata;
  end

  always_comb begin
    rsp_valid = '0;
    if (tag_data.valid) rsp_valid[tag_data.id] = 1'b1;
  end

  assign rsp_rdata = tag_data.valid ? mem_rdata : rdata_hold;

endmodule

// File: tb/tb_mem_bank_arbiter.sv
// Bench for mem_bank_arbiter: a banked memory model on the memory port, an
// access-level reference model checking every cycle, plus directed tables.
module tb_mem_bank_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_wen;
  logic [39:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_ready;
  logic [3:0]  rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        mem_wen;
  logic [9:0]  mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  int total = 0;
  int bad   = 0;

  mem_bank_arbiter #(.NREQ(4), .AW(10), .DW(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_wen   (req_wen),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .mem_wen   (mem_wen),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Four banks of 256 rows, synchronous read (old data on a same-edge write).
  logic [7:0] bank_mem [4][256];
  bit loaded = 1'b0;
  always @(posedge clk) begin
    if (!loaded) begin
      for (int b = 0; b < 4; b++)
        for (int r = 0; r < 256; r++) bank_mem[b][r] <= 8'h00;
      bank_mem[0][8'h80] <= 8'h29;
      mem_rdata <= 8'h00;
      loaded    <= 1'b1;
    end else begin
      mem_rdata <= bank_mem[mem_addr[9:8]][mem_addr[7:0]];
      if (mem_wen) bank_mem[mem_addr[9:8]][mem_addr[7:0]] <= mem_wdata;
    end
  end

  task automatic check_output(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: accesses take effect in grant order; a read returns
  // the data current at its grant, two cycles later.
  typedef struct {
    int         due;
    int         id;
    logic [7:0] data;
  } rsp_t;

  logic [7:0] model_mem [1024];
  rsp_t       rsp_q[$];
  int         cyc = 0;
  int         m_ptr = 0;
  int         iss_due = -1;
  logic       iss_wen;
  logic [9:0] iss_addr;
  logic [7:0] iss_wdata;
  logic [9:0] last_addr;
  logic [7:0] last_wdata;
  logic [7:0] last_rdata;

  task automatic model_cycle();
    int g;
    logic [9:0] a;
    cyc++;
    if (rst) begin
      check_output("rst_ready", req_ready, 0);
      check_output("rst_mem_wen", mem_wen, 0);
      check_output("rst_mem_addr", mem_addr, 0);
      check_output("rst_mem_wdata", mem_wdata, 0);
      check_output("rst_rsp_valid", rsp_valid, 0);
      check_output("rst_rsp_rdata", rsp_rdata, 0);
      rsp_q.delete();
      m_ptr = 0;
      iss_due = -1;
      last_addr = '0;
      last_wdata = '0;
      last_rdata = '0;
      return;
    end
    if (iss_due == cyc) begin
      check_output("issue_wen", mem_wen, iss_wen);
      check_output("issue_addr", mem_addr, iss_addr);
      check_output("issue_wdata", mem_wdata, iss_wdata);
      last_addr = iss_addr;
      last_wdata = iss_wdata;
    end else begin
      check_output("idle_wen", mem_wen, 0);
      check_output("idle_addr_hold", mem_addr, last_addr);
      check_output("idle_wdata_hold", mem_wdata, last_wdata);
    end
    if (rsp_q.size() > 0 && rsp_q[0].due == cyc) begin
      check_output("rsp_valid", rsp_valid, 32'd1 << rsp_q[0].id);
      check_output("rsp_rdata", rsp_rdata, rsp_q[0].data);
      last_rdata = rsp_q[0].data;
      void'(rsp_q.pop_front());
    end else begin
      check_output("no_rsp_valid", rsp_valid, 0);
      check_output("rsp_rdata_hold", rsp_rdata, last_rdata);
    end
    g = -1;
    for (int k = 0; k < 4; k++)
      if (g < 0 && req_valid[(m_ptr + k) % 4]) g = (m_ptr + k) % 4;
    check_output("grant", req_ready, (g < 0) ? 0 : (32'd1 << g));
    if (g >= 0) begin
      m_ptr = (g + 1) % 4;
      a = req_addr[g*10 +: 10];
      iss_due = cyc + 1;
      iss_wen = req_wen[g];
      iss_addr = a;
      iss_wdata = req_wdata[g*8 +: 8];
      if (req_wen[g]) model_mem[a] = req_wdata[g*8 +: 8];
      else rsp_q.push_back('{due: cyc + 2, id: g, data: model_mem[a]});
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      #3;
      model_cycle();
    end
  end

  task automatic clear_all();
    req_valid = '0;
    req_wen   = '0;
  endtask

  task automatic set_req(int i, logic wen, logic [9:0] a, logic [7:0] d);
    req_valid[i] = 1'b1;
    req_wen[i]   = wen;
    req_addr[i*10 +: 10] = a;
    req_wdata[i*8 +: 8]  = d;
  endtask

  task automatic apply_stimulus(logic [3:0] valid, logic [3:0] wen);
    @(negedge clk);
    clear_all();
    for (int i = 0; i < 4; i++)
      if (valid[i]) set_req(i, wen[i], 10'h000, 8'h00);
  endtask

  typedef struct {
    logic [3:0] valid;
    logic [3:0] ready;
  } vec_t;

  vec_t vecs[$];

  initial begin
    rst = 1'b1;
    req_valid = '0;
    req_wen = '0;
    req_addr = '0;
    req_wdata = '0;
    for (int i = 0; i < 1024; i++) model_mem[i] = 8'h00;
    model_mem[10'h080] = 8'h29;

    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Round-robin over all four, then a sparse pattern starting from ptr=1.
    vecs = '{
      '{4'b1111, 4'b0001}, '{4'b1111, 4'b0010}, '{4'b1111, 4'b0100}, '{4'b1111, 4'b1000},
      '{4'b1111, 4'b0001}, '{4'b1111, 4'b0010}, '{4'b1111, 4'b0100}, '{4'b1111, 4'b1000},
      '{4'b1111, 4'b0001}, '{4'b0101, 4'b0100}, '{4'b0101, 4'b0001}, '{4'b0101, 4'b0100},
      '{4'b0000, 4'b0000}, '{4'b0110, 4'b0010}, '{4'b1010, 4'b1000}, '{4'b0011, 4'b0001},
      '{4'b0011, 4'b0010}
    };
    foreach (vecs[v]) begin
      apply_stimulus(vecs[v].valid, 4'b0000);
      #4 check_output($sformatf("table_grant_%0d", v), req_ready, vecs[v].ready);
    end
    apply_stimulus(4'b0000, 4'b0000);
    repeat (2) @(negedge clk);

    // Single write then read of the same address by requester 0.
    @(negedge clk); clear_all(); set_req(0, 1'b1, 10'h280, 8'hF7);
    #4 check_output("wr_grant", req_ready, 4'b0001);
    @(negedge clk); clear_all(); set_req(0, 1'b0, 10'h280, 8'h00);
    #4 check_output("wr_issue_wen", mem_wen, 1);
    check_output("wr_issue_addr", mem_addr, 10'h280);
    check_output("wr_issue_wdata", mem_wdata, 8'hF7);
    @(negedge clk); clear_all();
    #4 check_output("rd_issue_wen", mem_wen, 0);
    @(negedge clk);
    #4 check_output("rd_rsp_valid", rsp_valid, 4'b0001);
    check_output("rd_rsp_rdata", rsp_rdata, 8'hF7);

    // Back-to-back reads from different requesters.
    @(negedge clk); clear_all(); set_req(1, 1'b0, 10'h080, 8'h00);
    @(negedge clk); clear_all(); set_req(3, 1'b0, 10'h000, 8'h00);
    @(negedge clk); clear_all();
    #4 check_output("pipe_rsp1_valid", rsp_valid, 4'b0010);
    check_output("pipe_rsp1_rdata", rsp_rdata, 8'h29);
    @(negedge clk);
    #4 check_output("pipe_rsp3_valid", rsp_valid, 4'b1000);
    check_output("pipe_rsp3_rdata", rsp_rdata, 8'h00);
    @(negedge clk);
    #4 check_output("pipe_rdata_hold", rsp_rdata, 8'h00);

    // Read-after-write on consecutive cycles from different requesters.
    @(negedge clk); clear_all(); set_req(0, 1'b1, 10'h100, 8'hA5);
    @(negedge clk); clear_all(); set_req(1, 1'b0, 10'h100, 8'h00);
    @(negedge clk); clear_all();
    @(negedge clk);
    #4 check_output("raw_rsp_valid", rsp_valid, 4'b0010);
    check_output("raw_rsp_rdata", rsp_rdata, 8'hA5);

    // Random traffic; the reference model checks every cycle.
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      clear_all();
      for (int i = 0; i < 4; i++) begin
        logic [1:0] bk;
        logic [1:0] rw;
        logic [7:0] d;
        bk = 2'($urandom_range(0, 3));
        rw = 2'($urandom_range(0, 3));
        d  = 8'($urandom);
        if ($urandom_range(0, 99) < 60)
          set_req(i, 1'($urandom_range(0, 1)), {bk, 6'd0, rw}, d);
      end
    end

    // Reset in the middle of a stream of reads.
    repeat (3) apply_stimulus(4'b1111, 4'b0000);
    apply_stimulus(4'b1111, 4'b0000);
    rst = 1'b1;
    #4 check_output("midrst_ready", req_ready, 0);
    check_output("midrst_mem_wen", mem_wen, 0);
    check_output("midrst_rsp_valid", rsp_valid, 0);
    apply_stimulus(4'b1111, 4'b0000);
    apply_stimulus(4'b1111, 4'b0000);
    rst = 1'b0;
    #4 check_output("post_rst_grant", req_ready, 4'b0001);
    check_output("post_rst_no_rsp0", rsp_valid, 0);
    apply_stimulus(4'b0000, 4'b0000);
    #4 check_output("post_rst_no_rsp1", rsp_valid, 0);
    @(negedge clk);
    #4 check_output("post_rst_new_rsp", rsp_valid, 4'b0001);

    repeat (4) apply_stimulus(4'b0000, 4'b0000);
    #4 check_output("rsp_queue_drained", rsp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
